// File: rtl/clk_div_pkg.sv
// Shared mode encodings and lock-qualifier state type for the divider bank.
package clk_div_pkg;

   localparam logic [1:0] MODE_TOGGLE = 2'b00;
   localparam logic [1:0] MODE_PULSE  = 2'b01;
   localparam logic [1:0] MODE_PWM    = 2'b10;
   localparam logic [1:0] MODE_RSVD   = 2'b11;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2
   } lock_state_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadowed config and registered waveform.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             active_i,
   input  logic [1:0]       mode_i,
   input  logic [WIDTH-1:0] div_i,
   input  logic [WIDTH-1:0] duty_i,
   output logic             tick_o,
   output logic             q_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sdiv_q, sdiv_d;
   logic [WIDTH-1:0] sduty_q, sduty_d;
   logic [1:0]       smode_q, smode_d;
   logic             tick_q, tick_d;
   logic             q_q, q_d;
   logic             at_end;

   assign at_end = (cnt_q == sdiv_q);

   // Shadows track the inputs while idle and only reload at a period end,
   // so a config write never truncates or stretches the running period.
   always_comb begin
      cnt_d   = '0;
      tick_d  = 1'b0;
      q_d     = 1'b0;
      sdiv_d  = div_i;
      sduty_d = duty_i;
      smode_d = mode_i;
      if (active_i) begin
         if (at_end) begin
            tick_d = 1'b1;
         end else begin
            cnt_d   = cnt_q + 1'b1;
            sdiv_d  = sdiv_q;
            sduty_d = sduty_q;
            smode_d = smode_q;
         end
         case (smode_q)
            MODE_TOGGLE: q_d = q_q ^ at_end;
            MODE_PULSE:  q_d = at_end;
            MODE_PWM:    q_d = (cnt_q < sduty_q);
            MODE_RSVD:   q_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         sdiv_q  <= '0;
         sduty_q <= '0;
         smode_q <= MODE_TOGGLE;
         tick_q  <= 1'b0;
         q_q     <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         sdiv_q  <= sdiv_d;
         sduty_q <= sduty_d;
         smode_q <= smode_d;
         tick_q  <= tick_d;
         q_q     <= q_d;
      end
   end

   assign tick_o = tick_q;
   assign q_o    = q_q;

endmodule

// File: rtl/clk_div_bank.sv
// Lock-qualified bank of independent programmable divider channels.
//   state     | meaning
//   WAIT_LOCK | waiting for locked; ready low, channels held clear
//   SETTLE    | locked seen; counting down the stability window
//   RUN       | lock qualified; ready high, enabled channels run
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int CHANNELS  = 4,
   parameter int WIDTH     = 16,
   parameter int LOCK_WAIT = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      locked,
   input  logic [CHANNELS-1:0]       en,
   input  logic [2*CHANNELS-1:0]     mode,
   input  logic [WIDTH*CHANNELS-1:0] div,
   input  logic [WIDTH*CHANNELS-1:0] duty,
   output logic                      ready,
   output logic [CHANNELS-1:0]       tick,
   output logic [CHANNELS-1:0]       q
);

   localparam int CW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
   localparam logic [CW-1:0] WAIT_LOAD = CW'(LOCK_WAIT - 1);

   lock_state_e   state_q;
   logic [CW-1:0] wait_q;
   logic          ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= WAIT_LOCK;
         wait_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               ready_q <= 1'b0;
               if (locked) begin
                  state_q <= SETTLE;
                  wait_q  <= WAIT_LOAD;
               end
            end
            SETTLE: begin
               if (!locked) begin
                  state_q <= WAIT_LOCK;
               end else if (wait_q == '0) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end else begin
                  wait_q <= wait_q - 1'b1;
               end
            end
            RUN: begin
               if (!locked) begin
                  state_q <= WAIT_LOCK;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= WAIT_LOCK;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign ready = ready_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      clk_div_chan #(.WIDTH(WIDTH)) u_chan (
         .clk      (clk),
         .rst      (rst),
         .active_i (en[g] & ready_q),
         .mode_i   (mode[2*g +: 2]),
         .div_i    (div[WIDTH*g +: WIDTH]),
         .duty_i   (duty[WIDTH*g +: WIDTH]),
         .tick_o   (tick[g]),
         .q_o      (q[g])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with a queue of expected per-cycle outputs.
module tb_clk_div_bank;

   localparam int CH = 4;
   localparam int W  = 16;
   localparam int LW = 16;

   logic            clk = 1'b0;
   logic            rst, locked;
   logic [CH-1:0]   en;
   logic [2*CH-1:0] mode;
   logic [W*CH-1:0] div, duty;
   logic            ready;
   logic [CH-1:0]   tick, q;
   logic [8:0]      obs;

   clk_div_bank #(.CHANNELS(CH), .WIDTH(W), .LOCK_WAIT(LW)) dut (
      .clk(clk), .rst(rst), .locked(locked), .en(en), .mode(mode),
      .div(div), .duty(duty), .ready(ready), .tick(tick), .q(q)
   );

   always #5 clk = ~clk;
   assign obs = {ready, tick, q};

   typedef struct {
      string      tag;
      logic [8:0] exp;
      logic [8:0] mask;
   } sb_t;

   sb_t sb_q[$];
   int  total = 0;
   int  bad   = 0;

   int         cfg_en[CH];
   logic [1:0] cfg_mode[CH];
   int         cfg_div[CH];
   int         cfg_duty[CH];

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(string tag, logic [8:0] o, logic [8:0] e, logic [8:0] m);
      total++;
      assert ((o & m) === (e & m)) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, o & m, e & m);
      end
   endtask

   task automatic push(string tag, logic [8:0] e, logic [8:0] m);
      sb_t s;
      s.tag = tag; s.exp = e; s.mask = m;
      sb_q.push_back(s);
   endtask

   task automatic step(int n);
      sb_t s;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            check(s.tag, obs, s.exp, s.mask);
         end
      end
   endtask

   task automatic drive();
      for (int i = 0; i < CH; i++) begin
         en[i]          = (cfg_en[i] != 0);
         mode[2*i +: 2] = cfg_mode[i];
         div[W*i +: W]  = W'(cfg_div[i]);
         duty[W*i +: W] = W'(cfg_duty[i]);
      end
   endtask

   // {tick,q} k cycles after a channel goes active with constant config
   function automatic logic [1:0] exp_ch(logic [1:0] m, int dv, int dt, int k);
      int   p;
      logic t, qq;
      p  = dv + 1;
      t  = (k >= 1) && (k % p == 0);
      qq = 1'b0;
      case (m)
         2'b00:   qq = ((k / p) % 2) == 1;
         2'b01:   qq = t;
         2'b10:   qq = (k >= 1) && (((k - 1) % p) < dt);
         default: qq = 1'b0;
      endcase
      return {t, qq};
   endfunction

   task automatic expect_run(string tag, int k0, int n);
      logic [8:0] e;
      logic [1:0] tq;
      for (int k = k0; k < k0 + n; k++) begin
         e = 9'h100;
         for (int i = 0; i < CH; i++) begin
            if (cfg_en[i] != 0) begin
               tq = exp_ch(cfg_mode[i], cfg_div[i], cfg_duty[i], k);
               e[4+i] = tq[1];
               e[i]   = tq[0];
            end
         end
         push(tag, e, 9'h1FF);
      end
      step(n);
   endtask

   task automatic set_cfg(int i, int e_, logic [1:0] m, int dv, int dt);
      cfg_en[i] = e_; cfg_mode[i] = m; cfg_div[i] = dv; cfg_duty[i] = dt;
   endtask

   task automatic all_off();
      for (int i = 0; i < CH; i++) cfg_en[i] = 0;
   endtask

   task automatic en_all(int v);
      for (int i = 0; i < CH; i++) cfg_en[i] = v;
   endtask

   initial begin
      logic [8:0] e;
      logic       t0;
      logic [1:0] tq;

      rst = 1'b1; locked = 1'b0;
      for (int i = 0; i < CH; i++) set_cfg(i, 0, 2'b00, 0, 0);
      drive();
      step(3);
      check("reset_state", obs, 9'h000, 9'h1FF);

      // lock qualification: locked high at cycle 10 -> ready at cycle 27
      rst = 1'b0;
      step(10);
      locked = 1'b1;
      repeat (LW) push("lock_wait", 9'h000, 9'h1FF);
      push("lock_ready", 9'h100, 9'h1FF);
      step(LW + 1);

      // glitch during SETTLE restarts qualification
      locked = 1'b0;
      step(2);
      check("unlock_ready", obs, 9'h000, 9'h100);
      locked = 1'b1;
      repeat (5) push("glitch_settle", 9'h000, 9'h100);
      step(5);
      locked = 1'b0;
      push("glitch_low", 9'h000, 9'h100);
      step(1);
      locked = 1'b1;
      repeat (LW) push("glitch_wait", 9'h000, 9'h100);
      push("glitch_ready", 9'h100, 9'h100);
      step(LW + 1);

      // toggle div4, pwm duty 3 / 0 / 12 on div9
      set_cfg(0, 0, 2'b00, 4, 0);
      set_cfg(1, 0, 2'b10, 9, 3);
      set_cfg(2, 0, 2'b10, 9, 0);
      set_cfg(3, 0, 2'b10, 9, 12);
      drive();
      step(1);
      en_all(1);
      drive();
      expect_run("run_modes", 1, 20);
      all_off();
      drive();
      push("en_off", 9'h100, 9'h1FF);
      step(1);

      // mid-period reconfig: pulse div7 changed to 2 at cnt=3; ch1 reserved div1
      set_cfg(0, 0, 2'b01, 7, 0);
      set_cfg(1, 0, 2'b11, 1, 0);
      drive();
      step(1);
      cfg_en[0] = 1; cfg_en[1] = 1;
      drive();
      for (int k = 1; k <= 16; k++) begin
         t0 = (k == 8) || (k > 8 && ((k - 8) % 3 == 0));
         tq = exp_ch(2'b11, 1, 0, k);
         e  = {1'b1, 2'b00, tq[1], t0, 2'b00, tq[0], t0};
         push("reconfig", e, 9'h1FF);
      end
      step(3);
      cfg_div[0] = 2;
      drive();
      step(13);
      all_off();
      drive();
      push("reconfig_off", 9'h100, 9'h1FF);
      step(1);

      // lock loss with all four channels running, then relock
      set_cfg(0, 0, 2'b00, 4, 0);
      set_cfg(1, 0, 2'b10, 9, 3);
      set_cfg(2, 0, 2'b01, 2, 0);
      set_cfg(3, 0, 2'b00, 0, 0);
      drive();
      step(1);
      en_all(1);
      drive();
      expect_run("pre_loss", 1, 12);
      locked = 1'b0;
      push("loss_ready", 9'h000, 9'h100);
      repeat (4) push("loss_clear", 9'h000, 9'h1FF);
      step(5);
      locked = 1'b1;
      repeat (LW) push("relock_wait", 9'h000, 9'h1FF);
      step(LW);
      expect_run("relock_run", 0, 13);

      // synchronous reset mid-run forces full requalification
      rst = 1'b1;
      push("rst_clear", 9'h000, 9'h1FF);
      step(1);
      rst = 1'b0;
      repeat (LW) push("rst_requal", 9'h000, 9'h1FF);
      step(LW);
      expect_run("rst_run", 0, 8);

      total++;
      assert (sb_q.size() == 0) else begin
         bad++;
         $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
